// File: rtl/exception_status_unit.sv
// Exception status unit: classifies ALU/mul-div exceptions into rstatus codes,
// issues one-cycle rstatus writes, buffers one collision, keeps debug state.
//
// Ports:
//   clock, reset (async active-low)
//   ex_valid, ex_opcode, ex_aluop, alu_overflow : EX-stage ALU overflow source
//   md_done, md_is_div, md_exception            : mul/div exception source
//   clear_status                                : sync clear of sticky/counter
//   ex_suppress_rd                              : comb, block rd write this cycle
//   stall_req                                   : pending slot occupied
//   wb_rstatus_we/addr/value                    : writeback request
//   sticky_code, exc_count                      : debug state
module exception_status_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RSTATUS_ADDR = 30,
    parameter int COUNT_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [4:0]            ex_opcode,
    input  logic [4:0]            ex_aluop,
    input  logic                  alu_overflow,
    input  logic                  md_done,
    input  logic                  md_is_div,
    input  logic                  md_exception,
    input  logic                  clear_status,
    output logic                  ex_suppress_rd,
    output logic                  stall_req,
    output logic                  wb_rstatus_we,
    output logic [REG_ADDR_W-1:0] wb_rstatus_addr,
    output logic [DATA_WIDTH-1:0] wb_rstatus_value,
    output logic [2:0]            sticky_code,
    output logic [COUNT_W-1:0]    exc_count
);

    localparam logic [2:0] CODE_ADD  = 3'd1;
    localparam logic [2:0] CODE_ADDI = 3'd2;
    localparam logic [2:0] CODE_SUB  = 3'd3;
    localparam logic [2:0] CODE_MUL  = 3'd4;
    localparam logic [2:0] CODE_DIV  = 3'd5;

    logic               we_q, we_d;
    logic [2:0]         code_q, code_d;
    logic               pend_v_q, pend_v_d;
    logic [2:0]         pend_code_q, pend_code_d;
    logic [2:0]         sticky_q, sticky_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic               is_add, is_sub, is_addi;
    logic               ea, em;
    logic [2:0]         alu_code, md_code;

    assign is_add  = (ex_opcode == 5'b00000) && (ex_aluop == 5'b00000);
    assign is_sub  = (ex_opcode == 5'b00000) && (ex_aluop == 5'b00001);
    assign is_addi = (ex_opcode == 5'b00101);

    assign ea = ex_valid && alu_overflow && (is_add || is_sub || is_addi);
    assign em = md_done && md_exception;

    always_comb begin
        alu_code = CODE_ADD;
        if (is_sub) begin
            alu_code = CODE_SUB;
        end else if (is_addi) begin
            alu_code = CODE_ADDI;
        end
    end

    assign md_code = md_is_div ? CODE_DIV : CODE_MUL;

    // Output register and pending slot. The pending entry always drains
    // first; upstream is stalled while it is occupied.
    always_comb begin
        we_d        = 1'b0;
        code_d      = code_q;
        pend_v_d    = 1'b0;
        pend_code_d = pend_code_q;
        if (pend_v_q) begin
            we_d   = 1'b1;
            code_d = pend_code_q;
        end else if (ea && em) begin
            we_d        = 1'b1;
            code_d      = alu_code;
            pend_v_d    = 1'b1;
            pend_code_d = md_code;
        end else if (ea) begin
            we_d   = 1'b1;
            code_d = alu_code;
        end else if (em) begin
            we_d   = 1'b1;
            code_d = md_code;
        end
    end

    // Debug state tracks the strobe being loaded, so it is current in the
    // same cycle the strobe is visible. A clear coinciding with that load
    // leaves the new code and a count of one.
    always_comb begin
        sticky_d = clear_status ? 3'd0 : sticky_q;
        cnt_d    = clear_status ? '0 : cnt_q;
        if (we_d) begin
            sticky_d = code_d;
            if (cnt_d != {COUNT_W{1'b1}}) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q        <= 1'b0;
            code_q      <= 3'd0;
            pend_v_q    <= 1'b0;
            pend_code_q <= 3'd0;
            sticky_q    <= 3'd0;
            cnt_q       <= '0;
        end else begin
            we_q        <= we_d;
            code_q      <= code_d;
            pend_v_q    <= pend_v_d;
            pend_code_q <= pend_code_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_suppress_rd   = ea;
    assign stall_req        = pend_v_q;
    assign wb_rstatus_we    = we_q;
    assign wb_rstatus_addr  = REG_ADDR_W'(RSTATUS_ADDR);
    assign wb_rstatus_value = DATA_WIDTH'(code_q);
    assign sticky_code      = sticky_q;
    assign exc_count        = cnt_q;

    // Upstream must not present events while the pending slot drains.
    a_no_event_while_pending : assert property (
        @(posedge clock) disable iff (!reset) pend_v_q |-> !(ea || em)
    );

endmodule

// File: tb/tb_exception_status_unit.sv
// Testbench for exception_status_unit: table-driven single events plus
// hand-written collision, saturation, clear and reset sequences.
module tb_exception_status_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, alu_overflow, md_done, md_is_div, md_exception;
    logic        clear_status;
    logic [4:0]  ex_opcode, ex_aluop;
    logic        sup, stall, we;
    logic [4:0]  addr;
    logic [31:0] val;
    logic [2:0]  sticky;
    logic [7:0]  cnt;
    logic        s_sup, s_stall, s_we;
    logic [4:0]  s_addr;
    logic [31:0] s_val;
    logic [2:0]  s_sticky;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt;
    int exp_sticky;

    always #5 clk = ~clk;

    exception_status_unit u_dut (
        .clock(clk), .reset(rst_n),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_aluop(ex_aluop),
        .alu_overflow(alu_overflow), .md_done(md_done),
        .md_is_div(md_is_div), .md_exception(md_exception),
        .clear_status(clear_status),
        .ex_suppress_rd(sup), .stall_req(stall),
        .wb_rstatus_we(we), .wb_rstatus_addr(addr),
        .wb_rstatus_value(val), .sticky_code(sticky), .exc_count(cnt)
    );

    exception_status_unit #(.COUNT_W(2)) u_sat (
        .clock(clk), .reset(rst_n),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_aluop(ex_aluop),
        .alu_overflow(alu_overflow), .md_done(md_done),
        .md_is_div(md_is_div), .md_exception(md_exception),
        .clear_status(clear_status),
        .ex_suppress_rd(s_sup), .stall_req(s_stall),
        .wb_rstatus_we(s_we), .wb_rstatus_addr(s_addr),
        .wb_rstatus_value(s_val), .sticky_code(s_sticky), .exc_count(s_cnt)
    );

    typedef struct {
        logic [4:0] op;
        logic [4:0] aluop;
        logic       ovf;
        logic       valid;
        logic       mdd;
        logic       div;
        logic       mdx;
        logic       e_sup;
        logic       e_we;
        int         e_val;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        ex_opcode    = 5'd0;
        ex_aluop     = 5'd0;
        alu_overflow = 1'b0;
        md_done      = 1'b0;
        md_is_div    = 1'b0;
        md_exception = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mul_exc();
        md_done      = 1'b1;
        md_is_div    = 1'b0;
        md_exception = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{5'b00000, 5'b00000, 1, 1, 0, 0, 0, 1, 1, 1};
        vecs[1]  = '{5'b00010, 5'b00000, 1, 1, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{5'b00000, 5'b00010, 1, 1, 0, 0, 0, 0, 0, 1};
        vecs[3]  = '{5'b00101, 5'b00000, 1, 1, 0, 0, 0, 1, 1, 2};
        vecs[4]  = '{5'b00000, 5'b00001, 1, 1, 0, 0, 0, 1, 1, 3};
        vecs[5]  = '{5'b00000, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 3};
        vecs[6]  = '{5'b00000, 5'b00000, 0, 1, 0, 0, 0, 0, 0, 3};
        vecs[7]  = '{5'b00000, 5'b00000, 0, 0, 1, 0, 1, 0, 1, 4};
        vecs[8]  = '{5'b00000, 5'b00000, 0, 0, 1, 1, 1, 0, 1, 5};
        vecs[9]  = '{5'b00000, 5'b00000, 0, 0, 1, 1, 0, 0, 0, 5};
        vecs[10] = '{5'b00000, 5'b00000, 0, 0, 0, 1, 1, 0, 0, 5};
        vecs[11] = '{5'b00101, 5'b00011, 1, 1, 0, 0, 0, 1, 1, 2};

        idle();
        rst_n = 1'b0;
        #12;
        chk("reset_we", int'(we), 0);
        chk("reset_val", int'(val), 0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_sticky", int'(sticky), 0);
        rst_n = 1'b1;
        step();

        exp_cnt    = 0;
        exp_sticky = 0;
        for (int i = 0; i < 12; i++) begin
            ex_opcode    = vecs[i].op;
            ex_aluop     = vecs[i].aluop;
            alu_overflow = vecs[i].ovf;
            ex_valid     = vecs[i].valid;
            md_done      = vecs[i].mdd;
            md_is_div    = vecs[i].div;
            md_exception = vecs[i].mdx;
            #1;
            chk($sformatf("v%0d_sup", i), int'(sup), int'(vecs[i].e_sup));
            step();
            idle();
            if (vecs[i].e_we) begin
                exp_cnt++;
                exp_sticky = vecs[i].e_val;
            end
            chk($sformatf("v%0d_we", i), int'(we), int'(vecs[i].e_we));
            chk($sformatf("v%0d_val", i), int'(val), vecs[i].e_val);
            chk($sformatf("v%0d_addr", i), int'(addr), 30);
            chk($sformatf("v%0d_cnt", i), int'(cnt), exp_cnt);
            chk($sformatf("v%0d_sticky", i), int'(sticky), exp_sticky);
        end
        step();
        chk("strobe_one_cycle", int'(we), 0);

        // clear alone
        clear_status = 1'b1;
        step();
        idle();
        chk("clear_cnt", int'(cnt), 0);
        chk("clear_sticky", int'(sticky), 0);
        chk("clear_val_kept", int'(val), 2);

        // simultaneous sub overflow and div-by-zero
        ex_valid     = 1'b1;
        alu_overflow = 1'b1;
        ex_aluop     = 5'b00001;
        md_done      = 1'b1;
        md_is_div    = 1'b1;
        md_exception = 1'b1;
        step();
        idle();
        chk("col1_we", int'(we), 1);
        chk("col1_val", int'(val), 3);
        chk("col1_stall", int'(stall), 1);
        step();
        chk("col2_we", int'(we), 1);
        chk("col2_val", int'(val), 5);
        chk("col2_stall", int'(stall), 0);
        chk("col2_cnt", int'(cnt), 2);
        chk("col2_sticky", int'(sticky), 5);
        step();
        chk("col3_we", int'(we), 0);

        // saturation of the 2-bit counter
        clear_status = 1'b1;
        step();
        idle();
        for (int k = 0; k < 5; k++) begin
            mul_exc();
            step();
            idle();
            chk($sformatf("sat%0d_cnt", k), int'(s_cnt), (k < 3) ? k + 1 : 3);
        end
        chk("sat_main_cnt", int'(cnt), 5);
        mul_exc();
        clear_status = 1'b1;
        step();
        idle();
        chk("clr_strobe_cnt", int'(cnt), 1);
        chk("clr_strobe_sat_cnt", int'(s_cnt), 1);
        chk("clr_strobe_sticky", int'(sticky), 4);
        chk("clr_strobe_we", int'(we), 1);

        // reset while pending slot is full
        step();
        ex_valid     = 1'b1;
        alu_overflow = 1'b1;
        mul_exc();
        step();
        idle();
        chk("rstp_stall_before", int'(stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstp_we", int'(we), 0);
        chk("rstp_val", int'(val), 0);
        chk("rstp_stall", int'(stall), 0);
        chk("rstp_cnt", int'(cnt), 0);
        chk("rstp_sticky", int'(sticky), 0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst%0d_we", k), int'(we), 0);
        end
        ex_valid     = 1'b1;
        alu_overflow = 1'b1;
        step();
        idle();
        chk("post_rst_new_we", int'(we), 1);
        chk("post_rst_new_val", int'(val), 1);
        chk("post_rst_new_cnt", int'(cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
